edge_serdes: RTL
================

EDGE_SERDES -- requirements
Module: edge_serdes

Interface
REQ-001 SHALL have parameter LANES, default 32, number of bit-serial lanes (one per edge wire, ARRAY_DIM*TILE_DIM*8).
REQ-002 SHALL have parameter MAX_WORD_LENGTH, default 32, maximum word length in bits per lane.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mode  input  2  00 idle, 01 drive (parallel->serial), 10 capture (serial->parallel), 11 pass (serial in->serial out plus capture).
REQ-006 SHALL have port start  input  1  single-cycle request to begin a transfer.
REQ-007 SHALL have port abort  input  1  terminate an active transfer.
REQ-008 SHALL have port len  input  clog2(MAX_WORD_LENGTH)+1  word length for the transfer.
REQ-009 SHALL have port par_i  input  LANES*MAX_WORD_LENGTH  parallel words; lane l at [l*MAX_WORD_LENGTH +: MAX_WORD_LENGTH].
REQ-010 SHALL have port ser_i  input  LANES  serial bit per lane from the array edge.
REQ-011 SHALL have port ser_o  output  LANES  serial bit per lane to the array edge.
REQ-012 SHALL have port par_o  output  LANES*MAX_WORD_LENGTH  captured words, same lane packing as par_i.
REQ-013 SHALL have port busy  output  1  transfer in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start with mode!=00; RUN->DONE after L bit-cycles; DONE->IDLE unconditionally next cycle.
REQ-016 SHALL compute effective length L = MAX_WORD_LENGTH when len==0 or len>MAX_WORD_LENGTH, else len; L, mode and par_i latched in the start cycle.
REQ-017 SHALL transfer LSB first: bit-cycle k (k=0..L-1) handles word bit k.
REQ-018 SHALL, with start sampled in cycle 0, hold busy high in cycles 1..L, and done high only in cycle L+1.
REQ-019 SHALL, in drive mode, present ser_o[l] = latched word_l bit k in cycle k+1.
REQ-020 SHALL, in capture mode, sample ser_i[l] in cycle k+1 into bit k of lane l's shift register; ser_o held 0.
REQ-021 SHALL, in pass mode, present ser_o[l] = ser_i[l] sampled one cycle earlier (first pass bit in cycle 2, last in cycle L+1) and capture as in capture mode.
REQ-022 SHALL update par_o atomically at the end of cycle L (visible with done) in capture/pass modes, bits >= L of each lane zero; par_o unchanged by drive mode.
REQ-023 SHALL drive ser_o to 0 whenever not in RUN, except the final pass-mode bit in DONE.
REQ-024 SHALL ignore start while busy or in DONE, and ignore start with mode==00 (no busy, no done).
REQ-025 SHALL ignore mode, len, par_i changes after the start cycle until the next accepted start.
REQ-026 SHALL, on abort in RUN, return to IDLE next cycle, clear ser_o and busy, emit no done, leave par_o unchanged; abort outside RUN has no effect.
REQ-027 SHALL give abort priority over start when both asserted in the same cycle.
REQ-028 SHALL accept start in the cycle after done (back-to-back transfers, no bubble beyond DONE).

Reset
REQ-029 SHALL, on reset (including mid-transfer), enter IDLE and set ser_o=0, par_o=0, busy=0, done=0, internal counter and shift registers 0.
REQ-030 SHALL give reset priority over abort and start.

Verification
REQ-031 Drive: LANES=2, MAX=8, len=4, par_i lane0=0x0B lane1=0x06 -> ser_o = 01,11,10,01 (lane1 lane0) cycles 1-4, done cycle 5.
REQ-032 Capture: len=8, ser_i lane0 bits LSB-first of 0xA5, lane1 0x3C -> par_o=0x3CA5 with done in cycle 9, busy cycles 1-8.
REQ-033 Length edge: len=0 and len=12 with MAX=8 -> both run 8 bit-cycles; len=1 -> busy one cycle, done cycle 2.
REQ-034 Pass: len=3, ser_i lane0 1,0,1 -> ser_o lane0 1,0,1 in cycles 2-4, par_o lane0=0x05.
REQ-035 Abort/reset: abort in cycle 2 of len=8 capture -> no done, par_o keeps prior value; reset in cycle 3 -> all outputs 0 next cycle.
REQ-036 Handshake: start held high through transfer with mode=01 -> one transfer per accepted start, restart in cycle after done, no start accepted while busy.

Source files
------------

// File: rtl/edge_serdes_if.sv
// Edge SERDES handshake/data bundle: transfer control in, serial and parallel data both ways.
interface edge_serdes_if #(
  parameter int LANES           = 32,
  parameter int MAX_WORD_LENGTH = 32
);
  localparam int LW = $clog2(MAX_WORD_LENGTH) + 1;

  logic [1:0]                       mode;
  logic                             start;
  logic                             abort;
  logic [LW-1:0]                    len;
  logic [LANES*MAX_WORD_LENGTH-1:0] par_i;
  logic [LANES-1:0]                 ser_i;
  logic [LANES-1:0]                 ser_o;
  logic [LANES*MAX_WORD_LENGTH-1:0] par_o;
  logic                             busy;
  logic                             done;

  modport master (output mode, start, abort, len, par_i, ser_i,
                  input  ser_o, par_o, busy, done);
  modport slave  (input  mode, start, abort, len, par_i, ser_i,
                  output ser_o, par_o, busy, done);
endinterface

// File: rtl/edge_serdes.sv
// Bit-serial edge SERDES: per-lane parallel<->serial conversion, LSB first,
// with drive, capture and pass-through modes sharing one bit-cycle counter.
module edge_serdes #(
  parameter int LANES           = 32,
  parameter int MAX_WORD_LENGTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  edge_serdes_if.slave  bus
);
  localparam int MW = MAX_WORD_LENGTH;
  localparam int LW = $clog2(MW) + 1;
  localparam int IW = $clog2(MW);

  localparam logic [1:0] M_DRIVE = 2'b01;
  localparam logic [1:0] M_PASS  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [1:0]               mode_q;
  logic [IW-1:0]            last_q;   // L-1, the final bit-cycle index
  logic [IW-1:0]            cnt;      // current bit-cycle index k
  logic [LANES-1:0][MW-1:0] par_w;
  logic [LANES-1:0][MW-1:0] sh;       // drive words, already advanced past the bit on ser_o
  logic [LANES-1:0][MW-1:0] cap;
  logic [LANES-1:0][MW-1:0] cap_nxt;
  logic [LW-1:0]            len_eff;
  logic [LW-1:0]            len_m1;
  logic [LANES-1:0]         ser_o_q;
  logic [LANES*MW-1:0]      par_o_q;
  logic                     busy_q;
  logic                     done_q;

  assign par_w     = bus.par_i;
  assign bus.ser_o = ser_o_q;
  assign bus.par_o = par_o_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  // Out-of-range or zero length means a full-width word.
  always_comb begin
    len_eff = (bus.len == '0 || bus.len > LW'(MW)) ? LW'(MW) : bus.len;
    len_m1  = len_eff - LW'(1);
  end

  // Capture word including this cycle's serial bit, so par_o can be loaded on the last bit.
  always_comb begin
    cap_nxt = cap;
    for (int l = 0; l < LANES; l++) cap_nxt[l][cnt] = bus.ser_i[l];
  end

  // Transfer FSM with registered outputs; reset beats abort, abort beats start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mode_q  <= '0;
      last_q  <= '0;
      cnt     <= '0;
      sh      <= '0;
      cap     <= '0;
      ser_o_q <= '0;
      par_o_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q  <= 1'b0;
          ser_o_q <= '0;
          if (bus.start && !bus.abort && bus.mode != 2'b00) begin
            state  <= RUN;
            busy_q <= 1'b1;
            mode_q <= bus.mode;
            last_q <= len_m1[IW-1:0];
            cnt    <= '0;
            cap    <= '0;
            for (int l = 0; l < LANES; l++) begin
              sh[l]      <= par_w[l] >> 1;
              ser_o_q[l] <= (bus.mode == M_DRIVE) ? par_w[l][0] : 1'b0;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            ser_o_q <= '0;
          end else begin
            cap <= cap_nxt;
            for (int l = 0; l < LANES; l++) sh[l] <= sh[l] >> 1;
            if (cnt == last_q) begin
              state   <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ser_o_q <= (mode_q == M_PASS) ? bus.ser_i : '0;
              if (mode_q[1]) par_o_q <= cap_nxt;
            end else begin
              cnt <= cnt + IW'(1);
              for (int l = 0; l < LANES; l++) begin
                case (mode_q)
                  M_DRIVE: ser_o_q[l] <= sh[l][0];
                  M_PASS:  ser_o_q[l] <= bus.ser_i[l];
                  default: ser_o_q[l] <= 1'b0;
                endcase
              end
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ser_o_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
